// File: rtl/oracle_tracker_if.sv
// Bus bundle for oracle_tracker: decode/writeback/commit event inputs,
// the outgoing event stream with its ready handshake, and the error status.
interface oracle_tracker_if #(
    parameter int NR_ENTRIES = 16
);
    localparam int IW = $clog2(NR_ENTRIES);

    logic          dec_valid_i;
    logic [IW-1:0] dec_id_i;
    logic [63:0]   dec_pc_i;
    logic [31:0]   dec_inst_i;
    logic          wb_valid_i;
    logic [IW-1:0] wb_id_i;
    logic [63:0]   wb_rdval_i;
    logic          cm_valid_i;
    logic [IW-1:0] cm_id_i;
    logic          in_ready_o;
    logic          evt_valid_o;
    logic [1:0]    evt_kind_o;
    logic [IW-1:0] evt_id_o;
    logic [63:0]   evt_pc_o;
    logic [63:0]   evt_data_o;
    logic          evt_ready_i;
    logic          err_o;
    logic [2:0]    err_code_o;

    // Pipeline side: produces instruction events and consumes the event stream.
    modport master (
        output dec_valid_i, dec_id_i, dec_pc_i, dec_inst_i,
        output wb_valid_i, wb_id_i, wb_rdval_i,
        output cm_valid_i, cm_id_i,
        output evt_ready_i,
        input  in_ready_o, evt_valid_o, evt_kind_o, evt_id_o, evt_pc_o, evt_data_o,
        input  err_o, err_code_o
    );

    // Tracker side.
    modport slave (
        input  dec_valid_i, dec_id_i, dec_pc_i, dec_inst_i,
        input  wb_valid_i, wb_id_i, wb_rdval_i,
        input  cm_valid_i, cm_id_i,
        input  evt_ready_i,
        output in_ready_o, evt_valid_o, evt_kind_o, evt_id_o, evt_pc_o, evt_data_o,
        output err_o, err_code_o
    );
endinterface

// File: rtl/oracle_tracker.sv
// In-order instruction lifecycle tracker. Checks decode/writeback/commit
// events against an id-indexed table, forwards accepted events through a
// small FIFO (up to three pushes per cycle) and latches the first error.
module oracle_tracker #(
    parameter int NR_ENTRIES = 16,
    parameter int FIFO_DEPTH = 8
) (
    input logic             clk_i,
    input logic             rst_ni,
    oracle_tracker_if.slave bus
);
    localparam int IW = $clog2(NR_ENTRIES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        KIND_DEC = 2'd0,
        KIND_WB  = 2'd1,
        KIND_CM  = 2'd2
    } kind_e;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_ALLOC = 3'd1,
        ERR_WB    = 3'd2,
        ERR_ORDER = 3'd3,
        ERR_OVF   = 3'd4
    } err_e;

    typedef struct packed {
        kind_e         kind;
        logic [IW-1:0] id;
        logic [63:0]   pc;
        logic [63:0]   data;
    } evt_t;

    // Instruction table and its pointers
    logic [NR_ENTRIES-1:0] valid_q;
    logic [NR_ENTRIES-1:0] written_q;
    logic [63:0]           pc_q [NR_ENTRIES];
    logic [IW-1:0]         alloc_ptr_q;
    logic [IW-1:0]         commit_ptr_q;

    // Event FIFO
    evt_t                  fifo_q [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr_q;
    logic [PW-1:0]         wr_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  ready_q;

    // Sticky error
    logic                  err_q;
    err_e                  err_code_q;

    // Per-cycle decisions
    logic                  any_valid;
    logic                  cm_ok;
    logic                  wb_ok;
    logic                  dec_ok;
    err_e                  err_cycle;
    evt_t                  push_evt [3];
    logic [1:0]            push_cnt;
    logic                  pop;
    logic [CW-1:0]         count_next;
    logic                  ready_next;

    // Advance a FIFO index by 0..3; depth is at least 4 so one wrap suffices.
    function automatic logic [PW-1:0] fifo_wrap(input logic [PW-1:0] idx, input int step);
        int sum;
        sum = int'(idx) + step;
        if (sum >= FIFO_DEPTH) sum = sum - FIFO_DEPTH;
        return PW'(sum);
    endfunction

    // Legality of each event against the pre-edge table, and the cycle's error code.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        any_valid = bus.dec_valid_i | bus.wb_valid_i | bus.cm_valid_i;
        cm_ok     = 1'b0;
        wb_ok     = 1'b0;
        dec_ok    = 1'b0;
        err_cycle = ERR_NONE;
        if (!ready_q) begin
            // Events offered while not ready are dropped wholesale.
            if (any_valid) err_cycle = ERR_OVF;
        end else begin
            // A writeback racing a commit of the same id makes that commit premature.
            cm_ok  = bus.cm_valid_i && (bus.cm_id_i == commit_ptr_q)
                   && valid_q[bus.cm_id_i] && written_q[bus.cm_id_i]
                   && !(bus.wb_valid_i && (bus.wb_id_i == bus.cm_id_i));
            wb_ok  = bus.wb_valid_i && valid_q[bus.wb_id_i] && !written_q[bus.wb_id_i];
            // A commit freeing the alloc slot this cycle lets a full table accept a decode.
            dec_ok = bus.dec_valid_i && (bus.dec_id_i == alloc_ptr_q)
                   && (!valid_q[alloc_ptr_q] || (cm_ok && (bus.cm_id_i == alloc_ptr_q)));
            // Later assignments win, so the lowest code is reported.
            if (bus.cm_valid_i && !cm_ok)   err_cycle = ERR_ORDER;
            if (bus.wb_valid_i && !wb_ok)   err_cycle = ERR_WB;
            if (bus.dec_valid_i && !dec_ok) err_cycle = ERR_ALLOC;
        end
    end

    // Pack accepted events into consecutive push slots: commit, writeback, decode.
    always_comb begin
        for (int i = 0; i < 3; i++) push_evt[i] = '0;
        push_cnt = 2'd0;
        if (cm_ok) begin
            push_evt[push_cnt] = '{kind: KIND_CM, id: bus.cm_id_i,
                                   pc: pc_q[bus.cm_id_i], data: 64'd0};
            push_cnt = push_cnt + 2'd1;
        end
        if (wb_ok) begin
            push_evt[push_cnt] = '{kind: KIND_WB, id: bus.wb_id_i,
                                   pc: pc_q[bus.wb_id_i], data: bus.wb_rdval_i};
            push_cnt = push_cnt + 2'd1;
        end
        if (dec_ok) begin
            push_evt[push_cnt] = '{kind: KIND_DEC, id: bus.dec_id_i,
                                   pc: bus.dec_pc_i, data: {32'd0, bus.dec_inst_i}};
            push_cnt = push_cnt + 2'd1;
        end
    end

    // FIFO occupancy after this edge and the resulting ready level.
    always_comb begin
        pop        = (count_q != '0) && bus.evt_ready_i;
        count_next = count_q + CW'(push_cnt) - CW'(pop);
        ready_next = (FIFO_DEPTH - int'(count_next)) >= 3;
    end

    // Table flags, pointers, FIFO bookkeeping and sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q      <= '0;
            written_q    <= '0;
            alloc_ptr_q  <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            ready_q      <= 1'b1;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            // NOTE: non-blocking updates with the decode after the commit, so a slot freed
            // and reallocated in the same cycle ends up valid (last assignment wins).
            if (cm_ok) begin
                valid_q[bus.cm_id_i] <= 1'b0;
                commit_ptr_q         <= commit_ptr_q + 1'b1;
            end
            if (wb_ok) written_q[bus.wb_id_i] <= 1'b1;
            if (dec_ok) begin
                valid_q[alloc_ptr_q]   <= 1'b1;
                written_q[alloc_ptr_q] <= 1'b0;
                alloc_ptr_q            <= alloc_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= fifo_wrap(rd_ptr_q, 1);
            wr_ptr_q <= fifo_wrap(wr_ptr_q, int'(push_cnt));
            count_q  <= count_next;
            ready_q  <= ready_next;
            if (!err_q && (err_cycle != ERR_NONE)) begin
                err_q      <= 1'b1;
                err_code_q <= err_cycle;
            end
        end
    end

    // Payload storage: table pcs and FIFO slots.
    always_ff @(posedge clk_i) begin
        // NOTE: storage arrays are not reset; valid bits and the occupancy count qualify them.
        if (dec_ok) pc_q[alloc_ptr_q] <= bus.dec_pc_i;
        for (int i = 0; i < 3; i++) begin
            if (i < int'(push_cnt)) fifo_q[fifo_wrap(wr_ptr_q, i)] <= push_evt[i];
        end
    end

    assign bus.in_ready_o  = ready_q;
    assign bus.evt_valid_o = (count_q != '0);
    assign bus.evt_kind_o  = fifo_q[rd_ptr_q].kind;
    assign bus.evt_id_o    = fifo_q[rd_ptr_q].id;
    assign bus.evt_pc_o    = fifo_q[rd_ptr_q].pc;
    assign bus.evt_data_o  = fifo_q[rd_ptr_q].data;
    assign bus.err_o       = err_q;
    assign bus.err_code_o  = err_code_q;
endmodule

// File: tb/tb_oracle_tracker.sv
// Bench for oracle_tracker: directed vector table, hand-written corner
// sequences and randomized traffic scored against an in-order ROB model.
module tb_oracle_tracker;
    localparam int NR = 16;
    localparam int FD = 8;
    localparam int IW = $clog2(NR);

    logic clk;
    logic rst_n;

    oracle_tracker_if #(.NR_ENTRIES(NR)) bus ();

    oracle_tracker #(.NR_ENTRIES(NR), .FIFO_DEPTH(FD)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          cm_v;
        int          cm_id;
        bit          wb_v;
        int          wb_id;
        logic [63:0] rdval;
        bit          dec_v;
        int          dec_id;
        logic [63:0] pc;
        logic [31:0] inst;
        bit          rdy;
    } stim_t;

    typedef struct {
        stim_t       s;
        bit          ev;
        int          kind;
        int          id;
        logic [63:0] pc;
        logic [63:0] data;
        bit          rdy_o;
        int          code;
    } vec_t;

    typedef struct {
        int          kind;
        int          id;
        logic [63:0] pc;
        logic [63:0] data;
    } ev_t;

    typedef struct {
        logic [63:0] pc;
        bit          written;
    } rob_t;

    // Reference model: in-flight instructions as an ordered window starting at
    // the commit id, plus the expected event stream as a queue.
    rob_t rob[$];
    ev_t  mq[$];
    int   m_cptr;
    bit   m_ready;
    bit   m_err;
    int   m_code;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic stim_t mk(bit cm_v, int cm_id, bit wb_v, int wb_id, logic [63:0] rdval,
                                 bit dec_v, int dec_id, logic [63:0] pc, logic [31:0] inst, bit rdy);
        stim_t s;
        s.cm_v = cm_v;   s.cm_id = cm_id;
        s.wb_v = wb_v;   s.wb_id = wb_id;   s.rdval = rdval;
        s.dec_v = dec_v; s.dec_id = dec_id; s.pc = pc; s.inst = inst;
        s.rdy = rdy;
        return s;
    endfunction

    function automatic stim_t idle(bit rdy);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endfunction
    function automatic stim_t st_dec(int id, logic [63:0] pc, logic [31:0] inst, bit rdy);
        return mk(0, 0, 0, 0, 0, 1, id, pc, inst, rdy);
    endfunction
    function automatic stim_t st_wb(int id, logic [63:0] rdval, bit rdy);
        return mk(0, 0, 1, id, rdval, 0, 0, 0, 0, rdy);
    endfunction
    function automatic stim_t st_cm(int id, bit rdy);
        return mk(1, id, 0, 0, 0, 0, 0, 0, 0, rdy);
    endfunction

    function automatic vec_t vec(stim_t s, bit ev, int kind, int id, logic [63:0] pc,
                                 logic [63:0] data, int code);
        vec_t v;
        v.s = s; v.ev = ev; v.kind = kind; v.id = id; v.pc = pc; v.data = data;
        v.rdy_o = 1'b1; v.code = code;
        return v;
    endfunction

    task automatic drive(input stim_t s);
        bus.cm_valid_i  = s.cm_v;
        bus.cm_id_i     = IW'(s.cm_id);
        bus.wb_valid_i  = s.wb_v;
        bus.wb_id_i     = IW'(s.wb_id);
        bus.wb_rdval_i  = s.rdval;
        bus.dec_valid_i = s.dec_v;
        bus.dec_id_i    = IW'(s.dec_id);
        bus.dec_pc_i    = s.pc;
        bus.dec_inst_i  = s.inst;
        bus.evt_ready_i = s.rdy;
    endtask

    task automatic model_reset();
        rob.delete();
        mq.delete();
        m_cptr  = 0;
        m_ready = 1'b1;
        m_err   = 1'b0;
        m_code  = 0;
    endtask

    // One clock edge of the tracker's rules applied to the model.
    task automatic model_step(input stim_t s);
        int size, aptr, woff, code;
        bit cm_ok, wb_ok, dec_ok;
        size   = rob.size();
        aptr   = (m_cptr + size) % NR;
        woff   = (s.wb_id - m_cptr + NR) % NR;
        code   = 0;
        cm_ok  = 1'b0;
        wb_ok  = 1'b0;
        dec_ok = 1'b0;
        if (s.rdy && mq.size() != 0) void'(mq.pop_front());
        if (!m_ready) begin
            if (s.cm_v || s.wb_v || s.dec_v) code = 4;
        end else begin
            cm_ok  = s.cm_v && s.cm_id == m_cptr && size > 0 && rob[0].written
                     && !(s.wb_v && s.wb_id == s.cm_id);
            wb_ok  = s.wb_v && woff < size && !rob[woff].written;
            dec_ok = s.dec_v && s.dec_id == aptr && (size < NR || cm_ok);
            if (s.dec_v && !dec_ok)     code = 1;
            else if (s.wb_v && !wb_ok)  code = 2;
            else if (s.cm_v && !cm_ok)  code = 3;
            if (cm_ok) mq.push_back('{2, s.cm_id, rob[0].pc, 64'd0});
            if (wb_ok) begin
                mq.push_back('{1, s.wb_id, rob[woff].pc, s.rdval});
                rob[woff].written = 1'b1;
            end
            if (dec_ok) mq.push_back('{0, s.dec_id, s.pc, {32'd0, s.inst}});
            if (cm_ok) begin
                void'(rob.pop_front());
                m_cptr = (m_cptr + 1) % NR;
            end
            if (dec_ok) rob.push_back('{s.pc, 1'b0});
        end
        if (code != 0 && !m_err) begin
            m_err  = 1'b1;
            m_code = code;
        end
        m_ready = (FD - mq.size()) >= 3;
    endtask

    task automatic compare_model();
        check("model.evt_valid", 64'(bus.evt_valid_o), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("model.evt_kind", 64'(bus.evt_kind_o), 64'(mq[0].kind));
            check("model.evt_id",   64'(bus.evt_id_o),   64'(mq[0].id));
            check("model.evt_pc",   bus.evt_pc_o,        mq[0].pc);
            check("model.evt_data", bus.evt_data_o,      mq[0].data);
        end
        check("model.in_ready", 64'(bus.in_ready_o), 64'(m_ready));
        check("model.err",      64'(bus.err_o),      64'(m_err));
        check("model.err_code", 64'(bus.err_code_o), 64'(m_code));
    endtask

    // Drive on the falling edge, let the rising edge act, sample 1 ns later.
    task automatic do_cycle(input stim_t s);
        @(negedge clk);
        drive(s);
        @(posedge clk);
        model_step(s);
        #1;
        compare_model();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        drive(idle(1'b0));
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_model();
    endtask

    // Random traffic; in clean mode only legal events are offered.
    function automatic stim_t rand_stim(bit clean);
        stim_t s;
        int size, aptr, off;
        bit cm_legal;
        s        = idle($urandom_range(0, 9) < 7);
        size     = rob.size();
        aptr     = (m_cptr + size) % NR;
        cm_legal = 1'b0;
        if (clean && !m_ready) return s;
        if ($urandom_range(0, 99) < 45) begin
            s.cm_v  = 1'b1;
            s.cm_id = (clean || $urandom_range(0, 9) < 8) ? m_cptr : int'($urandom_range(0, NR - 1));
            cm_legal = size > 0 && rob[0].written && s.cm_id == m_cptr;
            if (clean && !cm_legal) s.cm_v = 1'b0;
        end
        if (size > 0 && $urandom_range(0, 99) < 55) begin
            off     = int'($urandom_range(0, size - 1));
            s.wb_v  = 1'b1;
            s.wb_id = (m_cptr + off) % NR;
            s.rdval = {$urandom, $urandom};
            if (!clean && $urandom_range(0, 9) < 2) s.wb_id = int'($urandom_range(0, NR - 1));
            if (clean && rob[off].written) s.wb_v = 1'b0;
        end
        if ($urandom_range(0, 99) < 50) begin
            s.dec_v  = 1'b1;
            s.dec_id = (clean || $urandom_range(0, 9) < 8) ? aptr : int'($urandom_range(0, NR - 1));
            s.pc     = {$urandom, $urandom};
            s.inst   = $urandom;
            if (clean && size == NR && !(s.cm_v && cm_legal)) s.dec_v = 1'b0;
        end
        return s;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[11];
        int   n_fill;

        rst_n = 1'b0;
        drive(idle(1'b0));
        model_reset();

        // Directed table: basic lifecycle, then commit/writeback/decode in one cycle.
        vecs[0]  = vec(st_dec(0, 64'h1000, 32'h13, 1), 1, 0, 0, 64'h1000, 64'h13, 0);
        vecs[1]  = vec(st_wb(0, 64'd5, 1),              1, 1, 0, 64'h1000, 64'h5,  0);
        vecs[2]  = vec(st_cm(0, 1),                     1, 2, 0, 64'h1000, 64'h0,  0);
        vecs[3]  = vec(idle(1),                         0, 0, 0, 64'h0,    64'h0,  0);
        vecs[4]  = vec(st_dec(1, 64'h2000, 32'h21, 1), 1, 0, 1, 64'h2000, 64'h21, 0);
        vecs[5]  = vec(mk(0, 0, 1, 1, 64'h11, 1, 2, 64'h3000, 32'h31, 1),
                                                        1, 1, 1, 64'h2000, 64'h11, 0);
        vecs[6]  = vec(mk(1, 1, 1, 2, 64'h22, 1, 3, 64'h4000, 32'h41, 1),
                                                        1, 0, 2, 64'h3000, 64'h31, 0);
        vecs[7]  = vec(idle(1),                         1, 2, 1, 64'h2000, 64'h0,  0);
        vecs[8]  = vec(idle(1),                         1, 1, 2, 64'h3000, 64'h22, 0);
        vecs[9]  = vec(idle(1),                         1, 0, 3, 64'h4000, 64'h41, 0);
        vecs[10] = vec(idle(1),                         0, 0, 0, 64'h0,    64'h0,  0);

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset.evt_valid", 64'(bus.evt_valid_o), 64'd0);
        check("reset.in_ready",  64'(bus.in_ready_o),  64'd1);
        check("reset.err",       64'(bus.err_o),       64'd0);
        check("reset.err_code",  64'(bus.err_code_o),  64'd0);

        for (int i = 0; i < 11; i++) begin
            do_cycle(vecs[i].s);
            check($sformatf("vec%0d.evt_valid", i), 64'(bus.evt_valid_o), 64'(vecs[i].ev));
            if (vecs[i].ev) begin
                check($sformatf("vec%0d.kind", i), 64'(bus.evt_kind_o), 64'(vecs[i].kind));
                check($sformatf("vec%0d.id", i),   64'(bus.evt_id_o),   64'(vecs[i].id));
                check($sformatf("vec%0d.pc", i),   bus.evt_pc_o,        vecs[i].pc);
                check($sformatf("vec%0d.data", i), bus.evt_data_o,      vecs[i].data);
            end
            check($sformatf("vec%0d.in_ready", i), 64'(bus.in_ready_o), 64'(vecs[i].rdy_o));
            check($sformatf("vec%0d.err_code", i), 64'(bus.err_code_o), 64'(vecs[i].code));
        end

        // Full table, re-decode of id0, then commit-frees-decode of id0
        apply_reset();
        for (int i = 0; i < NR; i++) do_cycle(st_dec(i, 64'h1000 + 64'(i), 32'h100 + 32'(i), 1));
        check("full.err", 64'(bus.err_o), 64'd0);
        do_cycle(st_dec(0, 64'h9999, 32'h1, 1));
        check("full.alloc_code", 64'(bus.err_code_o), 64'd1);
        do_cycle(st_wb(0, 64'h77, 1));
        do_cycle(mk(1, 0, 0, 0, 0, 1, 0, 64'hABC0, 32'h77, 1));
        check("refill.kind0", 64'(bus.evt_kind_o), 64'd2);
        check("refill.pc0",   bus.evt_pc_o,        64'h1000);
        do_cycle(idle(1));
        check("refill.kind1", 64'(bus.evt_kind_o), 64'd0);
        check("refill.id1",   64'(bus.evt_id_o),   64'd0);
        check("refill.pc1",   bus.evt_pc_o,        64'hABC0);
        check("refill.code",  64'(bus.err_code_o), 64'd1);

        // Out-of-order commit is rejected and leaves commit_ptr at 0
        apply_reset();
        do_cycle(st_dec(0, 64'h10, 32'h1, 1));
        do_cycle(st_dec(1, 64'h20, 32'h2, 1));
        do_cycle(st_wb(1, 64'h5, 1));
        do_cycle(st_cm(1, 1));
        check("order.code",      64'(bus.err_code_o), 64'd3);
        check("order.no_event",  64'(bus.evt_valid_o), 64'd0);
        do_cycle(st_wb(0, 64'h6, 1));
        do_cycle(st_cm(0, 1));
        check("order.cm0_kind",  64'(bus.evt_kind_o), 64'd2);
        check("order.cm0_id",    64'(bus.evt_id_o),   64'd0);

        // Same-cycle writeback and commit of one id
        apply_reset();
        do_cycle(st_dec(0, 64'h40, 32'h4, 1));
        do_cycle(mk(1, 0, 1, 0, 64'h99, 0, 0, 0, 0, 1));
        check("wbcm.code", 64'(bus.err_code_o), 64'd3);
        check("wbcm.kind", 64'(bus.evt_kind_o), 64'd1);
        check("wbcm.data", bus.evt_data_o,      64'h99);

        // Backpressure until in_ready falls, then an overflowing decode
        apply_reset();
        n_fill = 0;
        for (int i = 0; i < 20; i++) begin
            do_cycle(st_dec(i, 64'h500 + 64'(i), 32'h50 + 32'(i), 0));
            n_fill++;
            if (!bus.in_ready_o) break;
        end
        check("ovf.fill_count", 64'(n_fill), 64'd6);
        do_cycle(st_dec(n_fill, 64'h5FF, 32'h5F, 0));
        check("ovf.code", 64'(bus.err_code_o), 64'd4);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ovf.drain%0d.id", i), 64'(bus.evt_id_o), 64'(i));
            check($sformatf("ovf.drain%0d.pc", i), bus.evt_pc_o, 64'h500 + 64'(i));
            do_cycle(idle(1));
        end
        check("ovf.drained", 64'(bus.evt_valid_o), 64'd0);

        // Asynchronous reset with events queued
        apply_reset();
        for (int i = 0; i < 5; i++) do_cycle(st_dec(i, 64'h700 + 64'(i), 32'h7, 0));
        check("areset.queued", 64'(bus.evt_valid_o), 64'd1);
        @(negedge clk);
        drive(idle(1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("areset.evt_valid", 64'(bus.evt_valid_o), 64'd0);
        check("areset.in_ready",  64'(bus.in_ready_o),  64'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_model();
        do_cycle(st_dec(0, 64'h800, 32'h8, 1));
        check("areset.dec_id0", 64'(bus.evt_id_o), 64'd0);
        do_cycle(st_wb(0, 64'h1, 1));
        do_cycle(st_cm(0, 1));
        check("areset.cm_kind", 64'(bus.evt_kind_o), 64'd2);
        check("areset.err",     64'(bus.err_o),      64'd0);

        // Randomized epochs: even epochs legal-only, odd epochs with errors
        for (int ep = 0; ep < 6; ep++) begin
            apply_reset();
            for (int c = 0; c < 400; c++) do_cycle(rand_stim(ep % 2 == 0));
            if (ep % 2 == 0) check($sformatf("rand%0d.clean_err", ep), 64'(bus.err_o), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
